// File: rtl/mac_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_seq_ctrl_pkg
// Purpose : Shared state encodings and multiplier widths for the MAC sequencer.
// Revision: 1.0  initial release
// ============================================================================
package mac_seq_ctrl_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_acc_stage.sv
`default_nettype none
// ============================================================================
// Module  : mac_acc_stage
// Purpose : Product register, two-deep valid pipeline and accumulator with
//           sticky overflow; saturation when MAC_SATURATE_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
import mac_seq_ctrl_pkg::*;

module mac_acc_stage #(
    parameter int ACC_W = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              xfer_i,
    input  logic [PROD_W-1:0] mul_p_i,
    output logic              v1_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    logic              v1_q;
    logic              v2_q;
    logic [PROD_W-1:0] p_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W:0]    sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, p_q};
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (v2_q) begin
            ovf_d = ovf_q | sum[ACC_W];
`ifdef MAC_SATURATE_EN
            // Once clamped, stay clamped until the next burst clears us.
            acc_d = (sum[ACC_W] || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            p_q   <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q  <= xfer_i;
            v2_q  <= v1_q;
            if (v1_q)
                p_q <= mul_p_i;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign v1_o  = v1_q;
    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mac_seq_ctrl
// Purpose : Burst sequencer and accumulator controller for an external 16x16
//           multiplier. Optional macro: MAC_SATURATE_EN (saturating acc).
// Revision: 1.0  initial release
// ============================================================================
import mac_seq_ctrl_pkg::*;

module mac_seq_ctrl #(
    parameter int ACC_W = 36,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  mul_a_q, mul_b_q;
    logic             busy_q, in_ready_q, out_valid_q;
    logic             xfer;
    logic             clr;
    logic             v1;

    assign xfer = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1))
                        state_d = DRAIN;
                end
            end
            // v1 low means the final product lands in acc on this edge.
            DRAIN: begin
                if (!v1)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == RUN) && (cnt_d != '0);
            out_valid_q <= (state_d == DONE);
            if (xfer) begin
                mul_a_q <= in_a;
                mul_b_q <= in_b;
            end
        end
    end

    mac_acc_stage #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .xfer_i  (xfer),
        .mul_p_i (mul_p),
        .v1_o    (v1),
        .acc_o   (out_acc),
        .ovf_o   (out_ovf)
    );

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire
